// File: rtl/noc_axi4_bridge_req_arb.sv
// Two-requester arbiter feeding an AXI4 request engine; tracks in-flight requests up to MAX_OUTSTANDING.
// Optional build macro NOC_AXI4_BRIDGE_REQ_ARB_STRICT_PRIO_EN: requester 0 wins every tie instead of round-robin.
`ifndef MSG_HEADER_WIDTH
`define MSG_HEADER_WIDTH 16
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif

module noc_axi4_bridge_req_arb #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [`MSG_HEADER_WIDTH-1:0] in0_header_i,
    input  logic [`AXI4_DATA_WIDTH-1:0]  in0_data_i,
    input  logic                         in0_val_i,
    output logic                         in0_rdy_o,
    input  logic [`MSG_HEADER_WIDTH-1:0] in1_header_i,
    input  logic [`AXI4_DATA_WIDTH-1:0]  in1_data_i,
    input  logic                         in1_val_i,
    output logic                         in1_rdy_o,
    output logic [`MSG_HEADER_WIDTH-1:0] out_header_o,
    output logic [`AXI4_DATA_WIDTH-1:0]  out_data_o,
    output logic                         out_src_o,
    output logic                         out_val_o,
    input  logic                         out_rdy_i,
    input  logic                         resp_done_i,
    output logic [3:0]                   outstanding_o,
    output logic                         err_underflow_o
);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_param
        $error("MAX_OUTSTANDING must be in 1..15");
    end

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       sel_q, sel_d;
    logic       rr_q, rr_d;
    logic [3:0] outst_q, outst_d;
    logic       err_q, err_d;
    logic       arb_en_q;
    logic       winner;
    logic       handshake;

    // Reset release is re-timed by one flop so the first grant can only be
    // latched on the second edge after rst_n_i rises.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            arb_en_q <= 1'b0;
        end else begin
            arb_en_q <= 1'b1;
        end
    end

    always_comb begin
        winner = in1_val_i;
        if (in0_val_i && in1_val_i) begin
`ifdef NOC_AXI4_BRIDGE_REQ_ARB_STRICT_PRIO_EN
            winner = 1'b0;
`else
            winner = ~rr_q;
`endif
        end
    end

    assign handshake = (state_q == ST_GRANT) && out_rdy_i;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        outst_d = outst_q;
        err_d   = err_q;

        case (state_q)
            ST_ARB: begin
                if (arb_en_q && (in0_val_i || in1_val_i) && (outst_q < MAX_OUT)) begin
                    sel_d   = winner;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (out_rdy_i) begin
                    state_d = ST_ARB;
`ifndef NOC_AXI4_BRIDGE_REQ_ARB_STRICT_PRIO_EN
                    rr_d    = sel_q;
`endif
                end
            end
            default: state_d = ST_ARB;
        endcase

        // A completion that coincides with a new acceptance cancels out.
        if (arb_en_q) begin
            if (handshake && !resp_done_i) begin
                outst_d = outst_q + 4'd1;
            end else if (!handshake && resp_done_i) begin
                if (outst_q == 4'd0) begin
                    err_d = 1'b1;
                end else begin
                    outst_d = outst_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_ARB;
            sel_q   <= 1'b0;
            rr_q    <= 1'b1;
            outst_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            outst_q <= outst_d;
            err_q   <= err_d;
        end
    end

    assign out_val_o       = (state_q == ST_GRANT);
    assign out_src_o       = sel_q;
    assign outstanding_o   = outst_q;
    assign err_underflow_o = err_q;
    assign in0_rdy_o       = handshake && !sel_q;
    assign in1_rdy_o       = handshake && sel_q;

    always_comb begin
        out_header_o = '0;
        out_data_o   = '0;
        if (state_q == ST_GRANT) begin
            out_header_o = sel_q ? in1_header_i : in0_header_i;
            out_data_o   = sel_q ? in1_data_i   : in0_data_i;
        end
    end

endmodule

// File: doc/noc_axi4_bridge_req_arb.md
NOC_AXI4_BRIDGE_REQ_ARB -- requirements
Module: noc_axi4_bridge_req_arb

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: maximum number of granted requests awaiting completion; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in0_header  input  `MSG_HEADER_WIDTH  header of the requester-0 message.
REQ-005 in0_data  input  `AXI4_DATA_WIDTH  payload of the requester-0 message.
REQ-006 in0_val  input  1  requester-0 message valid; held with stable header/data until in0_rdy.
REQ-007 in0_rdy  output  1  requester-0 message accepted this cycle.
REQ-008 in1_header, in1_data, in1_val, in1_rdy: same widths and meaning as REQ-004..007 for requester 1.
REQ-009 out_header  output  `MSG_HEADER_WIDTH  header of the granted message.
REQ-010 out_data  output  `AXI4_DATA_WIDTH  payload of the granted message.
REQ-011 out_src  output  1  index of the granted requester.
REQ-012 out_val  output  1  granted message valid.
REQ-013 out_rdy  input  1  downstream AXI request engine accepts the message.
REQ-014 resp_done  input  1  single-cycle pulse: one outstanding request completed.
REQ-015 outstanding  output  4  current in-flight count.
REQ-016 err_underflow  output  1  sticky flag: resp_done received while outstanding==0.

Function
REQ-017 Two states: ARB and GRANT.
REQ-018 In ARB, when (in0_val|in1_val) and outstanding<MAX_OUTSTANDING, the block SHALL latch the winner into the sel register and enter GRANT on the next edge; otherwise it SHALL remain in ARB.
REQ-019 Winner: the sole valid requester; if both are valid, the requester not equal to the rr register.
REQ-020 In GRANT, out_val SHALL be 1, out_src SHALL equal sel, and out_header/out_data SHALL be the combinational mux of the sel inputs.
REQ-021 In ARB, out_val SHALL be 0 and out_header/out_data SHALL be driven as all-zero.
REQ-022 inN_rdy SHALL equal (state==GRANT)&(sel==N)&out_rdy; the non-selected requester's rdy SHALL be 0.
REQ-023 On a GRANT cycle with out_rdy=1: rr SHALL be set to sel, outstanding SHALL increment, and state SHALL return to ARB.
REQ-024 GRANT SHALL hold indefinitely while out_rdy=0; the grant SHALL not change.
REQ-025 Latency: out_val SHALL rise one cycle after the qualifying inN_val; sustained throughput SHALL be one message per two cycles.
REQ-026 resp_done alone SHALL decrement outstanding.
REQ-027 resp_done coincident with an out handshake SHALL leave outstanding unchanged.
REQ-028 resp_done with outstanding==0 and no coincident handshake SHALL leave outstanding at 0 and set err_underflow.
REQ-029 While outstanding==MAX_OUTSTANDING, no new grant SHALL be issued; a resp_done in ARB SHALL allow a grant on the following edge.

Reset
REQ-030 Asserting rst_n low SHALL immediately force state=ARB, sel=0, rr=1 (so requester 0 wins the first tie), outstanding=0, err_underflow=0, out_val=0, out_src=0, in0_rdy=0, in1_rdy=0.
REQ-031 Reset asserted during GRANT SHALL drop the grant without a handshake; the requester keeps its val asserted and is re-arbitrated after release.
REQ-032 Deassertion of rst_n is synchronous to clk; the first grant SHALL appear no earlier than the second edge after release.

Configuration
REQ-033 Macro NOC_AXI4_BRIDGE_REQ_ARB_STRICT_PRIO_EN defined: requester 0 SHALL win every tie; rr is unused and held at reset value.
REQ-034 Macro undefined: round-robin per REQ-019; all other behaviour is identical in both builds.

Verification
REQ-035 Both val held, out_rdy=1, MAX=4, resp_done pulsed after each grant -> out_src sequence 0,1,0,1; one message per two cycles.
REQ-036 in0_val only, out_rdy=1, no resp_done -> four grants, outstanding=4, out_val stays 0; a single resp_done -> fifth grant two cycles later.
REQ-037 Grant issued, out_rdy=0 for 5 cycles, then 1 -> out_header stable for all 6 cycles, in_rdy pulses exactly once, and in the accept cycle outstanding goes 0->1.
REQ-038 Handshake and resp_done coincident with outstanding=2 -> outstanding stays 2; resp_done at outstanding=0 -> err_underflow=1 until reset.
REQ-039 rst_n low mid-GRANT with in1_val held -> out_val=0 asynchronously; after release, in1 is re-granted with identical header/data.
REQ-040 With STRICT_PRIO_EN defined and both val held -> out_src=0 for every grant while in0_val stays high.
